// File: rtl/dsp_access_ctrl.sv
// Display memory access controller.
// Arbitrates the single text-memory port between a host bus requester and an
// internal engine that clears the screen or scrolls it up by one line.
// The host always wins a cycle it requests, except the cycle of its own ack.
// As a result the engine is guaranteed at least every other cycle.
module dsp_access_ctrl #(
    parameter int ROWS = 30,
    parameter int COLS = 80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_stb,
    input  logic        host_we,
    input  logic [4:0]  host_row,
    input  logic [6:0]  host_col,
    input  logic [15:0] host_wr_data,
    output logic [15:0] host_rd_data,
    output logic        host_ack,
    input  logic        cmd_start,
    input  logic        cmd_op,
    input  logic [15:0] cmd_fill,
    output logic        busy,
    output logic        done,
    output logic [4:0]  dsp_row,
    output logic [6:0]  dsp_col,
    output logic        dsp_en,
    output logic        dsp_wr,
    output logic [15:0] dsp_wr_data,
    input  logic [15:0] dsp_rd_data
);

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);

    typedef enum logic [2:0] {IDLE, CLR, SC_RD, SC_WR, SC_FILL, FIN} state_t;

    state_t      state;
    logic [4:0]  row;
    logic [6:0]  col;
    logic [15:0] fill;
    logic [15:0] buf_q;
    logic        rd_fresh;   // engine read issued last cycle; its data is on dsp_rd_data now

    logic host_gnt;
    logic eng_issue;
    logic col_last;
    logic row_last;

    assign host_rd_data = dsp_rd_data;

    // Grant decision and display-port mux for the current cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        dsp_en      = 1'b0;
        dsp_wr      = 1'b0;
        dsp_row     = '0;
        dsp_col     = '0;
        dsp_wr_data = '0;

        // rst_n gates the host grant so the port stays quiet while reset is held.
        host_gnt  = rst_n & host_stb & ~host_ack;
        eng_issue = (state inside {CLR, SC_RD, SC_WR, SC_FILL}) & ~host_gnt;
        col_last  = (col == LAST_COL);
        row_last  = (row == LAST_ROW);

        if (host_gnt) begin
            dsp_en      = 1'b1;
            dsp_wr      = host_we;
            dsp_row     = host_row;
            dsp_col     = host_col;
            dsp_wr_data = host_wr_data;
        end else if (eng_issue) begin
            dsp_en  = 1'b1;
            dsp_col = col;
            case (state)
                SC_RD: begin
                    dsp_row = row;
                end
                SC_WR: begin
                    dsp_wr      = 1'b1;
                    dsp_row     = row - 5'd1;
                    dsp_wr_data = rd_fresh ? dsp_rd_data : buf_q;
                end
                default: begin
                    dsp_wr      = 1'b1;
                    dsp_row     = row;
                    dsp_wr_data = fill;
                end
            endcase
        end
    end

    // Engine sequencer, cell counters, read buffer and registered handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            fill     <= '0;
            buf_q    <= '0;
            rd_fresh <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            host_ack <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            host_ack <= host_gnt;
            rd_fresh <= eng_issue && (state == SC_RD);
            if (rd_fresh) buf_q <= dsp_rd_data;
            done <= 1'b0;

            case (state)
                IDLE, FIN: begin
                    state <= IDLE;
                    if (cmd_start) begin
                        fill  <= cmd_fill;
                        col   <= '0;
                        row   <= cmd_op ? 5'd1 : 5'd0;
                        state <= cmd_op ? SC_RD : CLR;
                        busy  <= 1'b1;
                    end
                end
                CLR: begin
                    if (eng_issue) begin
                        if (col_last) begin
                            col <= '0;
                            if (row_last) begin
                                state <= FIN;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                row <= row + 5'd1;
                            end
                        end else begin
                            col <= col + 7'd1;
                        end
                    end
                end
                SC_RD: begin
                    if (eng_issue) state <= SC_WR;
                end
                SC_WR: begin
                    if (eng_issue) begin
                        state <= SC_RD;
                        if (col_last) begin
                            col <= '0;
                            if (row_last) state <= SC_FILL;  // row stays at the bottom line
                            else          row   <= row + 5'd1;
                        end else begin
                            col <= col + 7'd1;
                        end
                    end
                end
                SC_FILL: begin
                    if (eng_issue) begin
                        if (col_last) begin
                            col   <= '0;
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            col <= col + 7'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_access_ctrl.sv
// Testbench for dsp_access_ctrl: a behavioural display memory, a screen-level
// reference model and a host-response scoreboard drained by a monitor.
module tb_dsp_access_ctrl;

    localparam int ROWS = 30;
    localparam int COLS = 80;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_stb = 1'b0, host_we = 1'b0;
    logic [4:0]  host_row = '0;
    logic [6:0]  host_col = '0;
    logic [15:0] host_wr_data = '0, host_rd_data;
    logic        host_ack;
    logic        cmd_start = 1'b0, cmd_op = 1'b0;
    logic [15:0] cmd_fill = '0;
    logic        busy, done;
    logic [4:0]  dsp_row;
    logic [6:0]  dsp_col;
    logic        dsp_en, dsp_wr;
    logic [15:0] dsp_wr_data, dsp_rd_data;

    always #5 clk = ~clk;

    dsp_access_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_stb(host_stb), .host_we(host_we), .host_row(host_row), .host_col(host_col),
        .host_wr_data(host_wr_data), .host_rd_data(host_rd_data), .host_ack(host_ack),
        .cmd_start(cmd_start), .cmd_op(cmd_op), .cmd_fill(cmd_fill),
        .busy(busy), .done(done),
        .dsp_row(dsp_row), .dsp_col(dsp_col), .dsp_en(dsp_en), .dsp_wr(dsp_wr),
        .dsp_wr_data(dsp_wr_data), .dsp_rd_data(dsp_rd_data)
    );

    // Display memory: full 32x128 array, 1-cycle synchronous read.
    logic [15:0] mem [32][128];
    logic [15:0] rd_q;
    always @(posedge clk) begin
        if (dsp_en) begin
            if (dsp_wr) mem[dsp_row][dsp_col] = dsp_wr_data;
            else        rd_q <= mem[dsp_row][dsp_col];
        end
    end
    assign dsp_rd_data = rd_q;

    // Expected screen contents.
    logic [15:0] model_mem [32][128];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          is_rd;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t e_mon;

    bit exp_ack = 1'b0;      // bench's own view of whether this cycle is an ack cycle
    int busy_grants = 0;     // host grants seen while the engine is busy

    // Monitor: ack timing, host grant port contents, quiet port when idle, scoreboard drain.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_ack = 1'b0;
        end else begin
            check("ack_timing", host_ack, exp_ack);
            if (host_ack) begin
                if (sb.size() == 0) check("ack_unexpected", 1, 0);
                else begin
                    e_mon = sb.pop_front();
                    if (e_mon.is_rd) check("host_rd", host_rd_data, e_mon.data);
                end
            end
            if (host_stb && !exp_ack) begin
                check("grant_port", {dsp_en, dsp_wr, dsp_row, dsp_col, host_we ? dsp_wr_data : 16'h0},
                                    {1'b1, host_we, host_row, host_col, host_we ? host_wr_data : 16'h0});
                if (busy) busy_grants++;
            end else if (!busy) begin
                check("idle_no_access", dsp_en, 0);
            end
            exp_ack = host_stb && !exp_ack;
        end
    end

    // One host access; leaves stb high when hold=1 so the next request is back-to-back.
    task automatic host_xfer(input bit we, input logic [4:0] r, input logic [6:0] c,
                             input logic [15:0] d, input bit hold);
        exp_t e;
        int n;
        e.is_rd = !we;
        e.data  = model_mem[r][c];
        if (we) model_mem[r][c] = d;
        sb.push_back(e);
        host_stb = 1'b1; host_we = we; host_row = r; host_col = c; host_wr_data = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!host_ack && n < 20);
        if (!host_ack) check("ack_timeout", 0, 1);
        if (!hold) host_stb = 1'b0;
    endtask

    int g0;

    // Issue a start pulse and update the reference screen for the operation.
    task automatic start_op(input bit op, input logic [15:0] f);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (op == 1'b0 || r == ROWS - 1) model_mem[r][c] = f;
                else                             model_mem[r][c] = model_mem[r + 1][c];
        g0 = busy_grants;
        cmd_start = 1'b1; cmd_op = op; cmd_fill = f;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        check("busy_rise", busy, 1);
    endtask

    // Measure busy length and the done pulse.
    task automatic wait_op(input int base);
        int cyc = 0;
        int guard = 0;
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            guard++;
            if (busy) begin
                seen = 1'b1;
                cyc++;
            end else if (seen) begin
                break;
            end
            if (guard > 20000) begin
                check("op_timeout", 0, 1);
                break;
            end
        end
        check("done_pulse", done, 1);
        @(negedge clk);
        check("done_width", done, 0);
        check("busy_cycles", cyc, base + (busy_grants - g0));
    endtask

    task automatic check_screen();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 128; c++)
                check($sformatf("cell_%0d_%0d", r, c), mem[r][c], model_mem[r][c]);
    endtask

    task automatic preload_ramp();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                mem[r][c] = 16'(r * 256 + c);
                model_mem[r][c] = mem[r][c];
            end
    endtask

    bit op_done;

    initial begin
        // Random background contents everywhere, including the unused rows/cols.
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 128; c++) begin
                mem[r][c] = 16'($urandom);
                model_mem[r][c] = mem[r][c];
            end

        // Reset: outputs quiet even with a host request pending.
        host_stb = 1'b1;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack", host_ack, 0);
        check("rst_dsp_en", dsp_en, 0);
        host_stb = 1'b0;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Host only: write then read back one cell.
        host_xfer(1'b1, 5'd3, 7'd5, 16'h1E41, 1'b0);
        host_xfer(1'b0, 5'd3, 7'd5, 16'h0, 1'b0);

        // Random host traffic with random gaps and back-to-back bursts.
        for (int i = 0; i < 30; i++) begin
            host_xfer(1'($urandom), 5'($urandom), 7'($urandom), 16'($urandom), 1'($urandom));
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; host_stb = 1'b0; end
        end
        host_stb = 1'b0;
        @(posedge clk); #1;
        check_screen();

        // Clear with idle host.
        start_op(1'b0, 16'h0720);
        wait_op(ROWS * COLS);
        check_screen();

        // Scroll with idle host on a ramp pattern.
        preload_ramp();
        @(posedge clk); #1;
        start_op(1'b1, 16'h0000);
        wait_op(2 * (ROWS - 1) * COLS + COLS);
        check_screen();

        // Scroll under continuous host reads; start coincides with the first host request.
        preload_ramp();
        @(posedge clk); #1;
        op_done = 1'b0;
        fork
            begin
                start_op(1'b1, 16'($urandom));
                wait_op(2 * (ROWS - 1) * COLS + COLS);
                op_done = 1'b1;
            end
            begin
                while (!op_done)
                    host_xfer(1'b0, 5'($urandom_range(31, 30)), 7'($urandom_range(127, 0)), 16'h0, 1'b1);
                host_stb = 1'b0;
            end
        join
        @(posedge clk); #1;
        check_screen();

        // Clear with a second start pulse mid-operation, which must be ignored.
        fork
            begin
                start_op(1'b0, 16'($urandom));
                wait_op(ROWS * COLS);
            end
            begin
                repeat (700) @(posedge clk);
                #1;
                cmd_start = 1'b1; cmd_op = 1'b1; cmd_fill = 16'($urandom);
                @(posedge clk); #1;
                cmd_start = 1'b0;
            end
        join
        check_screen();

        // Reset mid-scroll with a host ack pending.
        start_op(1'b1, 16'hBEEF);
        repeat (1000) @(posedge clk);
        #1;
        begin
            exp_t e;
            e.is_rd = 1'b0;
            e.data  = '0;
            sb.push_back(e);
        end
        host_stb = 1'b1; host_we = 1'b0; host_row = 5'd31; host_col = 7'd0;
        @(posedge clk); #1;
        check("pre_rst_ack", host_ack, 1);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_ack", host_ack, 0);
        check("async_dsp_en", dsp_en, 0);
        if (sb.size() != 0) void'(sb.pop_front());
        host_stb = 1'b0;
        @(posedge clk); #1;
        check("rst_held_done", done, 0);
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 128; c++)
                model_mem[r][c] = mem[r][c];
        @(posedge clk); #1;
        start_op(1'b0, 16'($urandom));
        wait_op(ROWS * COLS);
        check_screen();

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
